mcu_halt_responder: RTL and testbench
=====================================

MCU_HALT_RESPONDER -- requirements
Module: mcu_halt_responder

Interface
REQ-001 SHALL have parameter OUTSTANDING_WIDTH, default 3, width of the outstanding bus transaction counter.
REQ-002 SHALL have parameter DRAIN_TIMEOUT_WIDTH, default 8, width of the drain timeout counter.
REQ-003 SHALL have port clk  input  1  block clock.
REQ-004 SHALL have port mcu_rst_b  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mcu_cpu_halt_req_i  input  1  halt request from the boot sequencer.
REQ-006 SHALL have port mcu_cpu_halt_ack_o  output  1  one-cycle halt acknowledge.
REQ-007 SHALL have port mcu_cpu_halt_status_o  output  1  core halted, level.
REQ-008 SHALL have port mcu_cpu_run_req_i  input  1  resume request.
REQ-009 SHALL have port mcu_cpu_run_ack_o  output  1  one-cycle resume acknowledge.
REQ-010 SHALL have port core_stall_o  output  1  block new instruction issue.
REQ-011 SHALL have port core_idle_i  input  1  core pipeline empty.
REQ-012 SHALL have port bus_req_issue_i  input  1  bus transaction issued this cycle.
REQ-013 SHALL have port bus_rsp_done_i  input  1  bus transaction completed this cycle.
REQ-014 SHALL have port drain_timeout_o  output  1  sticky flag: halt forced by timeout.
REQ-015 SHALL have port outstanding_ovf_o  output  1  sticky flag: outstanding counter saturated.

Function
REQ-016 SHALL implement FSM states RUN, ACK, DRAIN, HALTED, RESUME, all outputs decoded from registered state or sticky flops.
REQ-017 RUN: stall=0, halt_ack=0, halt_status=0; halt_req_i=1 -> ACK.
REQ-018 ACK: halt_ack=1, stall=1, exactly one cycle; unconditional -> DRAIN.
REQ-019 DRAIN: stall=1; outstanding==0 && core_idle_i -> HALTED; else timeout counter at all-ones -> HALTED with drain_timeout_o set.
REQ-020 If drained and timeout coincide in the same cycle, drain wins; drain_timeout_o unchanged.
REQ-021 HALTED: halt_status=1, stall=1; run_req_i=1 && halt_req_i=0 -> RESUME; halt_req_i=1 blocks resume (halt priority).
REQ-022 RESUME: run_ack=1, halt_status=0, stall=0, exactly one cycle; -> RUN.
REQ-023 Once ACK is entered, halt is committed: deassertion of halt_req_i in ACK or DRAIN does not abort; the FSM still reaches HALTED.
REQ-024 run_req_i in any state other than HALTED SHALL be ignored, with no run_ack.
REQ-025 Latency: halt_req_i sampled high in RUN at cycle 0 -> ack_o high cycle 1 -> DRAIN cycle 2 -> status high at cycle 3 minimum.
REQ-026 Outstanding counter: +1 on issue only, -1 on done only, unchanged on both or neither; counts in all states.
REQ-027 Issue at max value: counter holds at all-ones; outstanding_ovf_o set sticky. Done at zero: ignored, counter stays 0.
REQ-028 Timeout counter: cleared on ACK->DRAIN; +1 each DRAIN cycle; saturates at all-ones; DRAIN cycles ≤ 2^DRAIN_TIMEOUT_WIDTH.
REQ-029 A halt_req_i that stays high through RESUME SHALL NOT occur (blocked by REQ-021); a new halt_req_i in RUN restarts the handshake.
REQ-030 No illegal state SHALL be reachable; an unknown encoding SHALL go to HALTED with status=1.

Reset
REQ-031 mcu_rst_b=0 at a clk edge SHALL set state=RUN, all outputs 0, both counters 0, both sticky flags 0.
REQ-032 Reset mid-handshake (ACK/DRAIN/HALTED) SHALL drop halt_status_o and stall_o the next cycle with no ack/run_ack pulse emitted.
REQ-033 The block SHALL sample no input while mcu_rst_b=0.

Verification
REQ-034 halt_req_i=1 at cycle 0, idle=1, outstanding=0 -> ack_o=1 cycle 1 only, status=1 from cycle 3, stall=1 from cycle 1.
REQ-035 Two issues then halt; dones at cycles 5,7 -> status=1 at cycle 8, drain_timeout_o=0.
REQ-036 core_idle_i=0 forever with DRAIN_TIMEOUT_WIDTH=8 -> HALTED after 256 DRAIN cycles, drain_timeout_o=1 sticky until reset.
REQ-037 HALTED with run_req=1 and halt_req=1 -> no run_ack; halt_req drops -> run_ack one cycle, status=0, then RUN.
REQ-038 8 issues, no dones, OUTSTANDING_WIDTH=3 -> counter=7, outstanding_ovf_o=1; done at count 0 -> count stays 0.
REQ-039 mcu_rst_b=0 in DRAIN -> next cycle state=RUN, all outputs 0, counters 0.

Source files
------------

// File: rtl/mcu_halt_responder.sv
// Core halt/resume handshake responder: stalls issue, drains bus traffic,
// and reports halted status with a bounded drain timeout.
module mcu_halt_responder #(
  parameter int OUTSTANDING_WIDTH   = 3,
  parameter int DRAIN_TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic mcu_rst_b,
  input  logic mcu_cpu_halt_req_i,
  output logic mcu_cpu_halt_ack_o,
  output logic mcu_cpu_halt_status_o,
  input  logic mcu_cpu_run_req_i,
  output logic mcu_cpu_run_ack_o,
  output logic core_stall_o,
  input  logic core_idle_i,
  input  logic bus_req_issue_i,
  input  logic bus_rsp_done_i,
  output logic drain_timeout_o,
  output logic outstanding_ovf_o
);

  localparam int OW = OUTSTANDING_WIDTH;
  localparam int TW = DRAIN_TIMEOUT_WIDTH;

  localparam logic [OW-1:0] O_MAX = {OW{1'b1}};
  localparam logic [OW-1:0] O_ONE = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] T_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_ACK    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_RESUME = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;
  logic          ovf_q;
  logic          ovf_d;

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          tmo_flag_q;
  logic          tmo_flag_d;

  logic          drained;
  logic          tmo_full;

  // Outstanding counter tracks bus traffic in every state.
  always_comb begin
    outst_d = outst_q;
    ovf_d   = ovf_q;
    if (bus_req_issue_i && !bus_rsp_done_i) begin
      if (outst_q == O_MAX) begin
        ovf_d = 1'b1;
      end else begin
        outst_d = outst_q + O_ONE;
      end
    end else if (bus_rsp_done_i && !bus_req_issue_i) begin
      if (outst_q != '0) begin
        outst_d = outst_q - O_ONE;
      end
    end
  end

  // A response landing this cycle counts toward the drain decision.
  assign drained  = (outst_d == '0) && core_idle_i;
  assign tmo_full = (tmo_q == T_MAX);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    unique case (state_q)
      ST_RUN: begin
        if (mcu_cpu_halt_req_i) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_DRAIN;
        tmo_d   = '0;
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_HALTED;
        end else if (tmo_full) begin
          state_d    = ST_HALTED;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + T_ONE;
        end
      end
      ST_HALTED: begin
        if (mcu_cpu_run_req_i && !mcu_cpu_halt_req_i) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mcu_rst_b) begin
      state_q    <= ST_RUN;
      outst_q    <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Outputs decode purely from registered state.
  always_comb begin
    mcu_cpu_halt_ack_o    = 1'b0;
    mcu_cpu_halt_status_o = 1'b0;
    mcu_cpu_run_ack_o     = 1'b0;
    core_stall_o          = 1'b0;
    unique case (state_q)
      ST_RUN: begin
      end
      ST_ACK: begin
        mcu_cpu_halt_ack_o = 1'b1;
        core_stall_o       = 1'b1;
      end
      ST_DRAIN: begin
        core_stall_o = 1'b1;
      end
      ST_HALTED: begin
        mcu_cpu_halt_status_o = 1'b1;
        core_stall_o          = 1'b1;
      end
      ST_RESUME: begin
        mcu_cpu_run_ack_o = 1'b1;
      end
      default: begin
        mcu_cpu_halt_status_o = 1'b1;
        core_stall_o          = 1'b1;
      end
    endcase
  end

  assign drain_timeout_o   = tmo_flag_q;
  assign outstanding_ovf_o = ovf_q;

endmodule

// File: tb/tb_mcu_halt_responder.sv
// Randomized and directed bench for mcu_halt_responder against a
// cycle-level behavioural model of the halt/resume handshake.
module tb_mcu_halt_responder;

  localparam int OW    = 3;
  localparam int TW    = 8;
  localparam int CMAX  = (1 << OW) - 1;
  localparam int DLIM  = (1 << TW);

  logic clk = 1'b0;
  logic mcu_rst_b = 1'b0;
  logic halt_req = 1'b0;
  logic run_req = 1'b0;
  logic idle = 1'b0;
  logic issue = 1'b0;
  logic done = 1'b0;
  logic halt_ack;
  logic halt_status;
  logic run_ack;
  logic stall;
  logic tmo;
  logic ovf;

  int checks = 0;
  int errors = 0;

  // model: phase 0 run, 1 ack, 2 drain, 3 halted, 4 resume
  int m_ph  = 0;
  int m_cnt = 0;
  int m_dc  = 0;
  bit m_tf  = 1'b0;
  bit m_of  = 1'b0;

  always #5 clk = ~clk;

  mcu_halt_responder #(
    .OUTSTANDING_WIDTH  (OW),
    .DRAIN_TIMEOUT_WIDTH(TW)
  ) dut (
    .clk                  (clk),
    .mcu_rst_b            (mcu_rst_b),
    .mcu_cpu_halt_req_i   (halt_req),
    .mcu_cpu_halt_ack_o   (halt_ack),
    .mcu_cpu_halt_status_o(halt_status),
    .mcu_cpu_run_req_i    (run_req),
    .mcu_cpu_run_ack_o    (run_ack),
    .core_stall_o         (stall),
    .core_idle_i          (idle),
    .bus_req_issue_i      (issue),
    .bus_rsp_done_i       (done),
    .drain_timeout_o      (tmo),
    .outstanding_ovf_o    (ovf)
  );

  function automatic logic [5:0] dut_v();
    return {halt_ack, halt_status, run_ack, stall, tmo, ovf};
  endfunction

  function automatic logic [5:0] exp_v();
    logic a, s, r, st;
    a  = (m_ph == 1);
    s  = (m_ph == 3);
    r  = (m_ph == 4);
    st = (m_ph >= 1) && (m_ph <= 3);
    return {a, s, r, st, m_tf, m_of};
  endfunction

  task automatic model_upd(input bit rst, hreq, rreq, idl, iss, dn);
    int nc;
    if (!rst) begin
      m_ph = 0; m_cnt = 0; m_dc = 0; m_tf = 0; m_of = 0;
      return;
    end
    nc = m_cnt;
    if (iss && !dn) begin
      if (m_cnt == CMAX) m_of = 1'b1;
      else nc = m_cnt + 1;
    end else if (dn && !iss && m_cnt > 0) begin
      nc = m_cnt - 1;
    end
    case (m_ph)
      0: if (hreq) m_ph = 1;
      1: begin m_ph = 2; m_dc = 0; end
      2: begin
        m_dc++;
        if (nc == 0 && idl) m_ph = 3;
        else if (m_dc == DLIM) begin m_ph = 3; m_tf = 1'b1; end
      end
      3: if (rreq && !hreq) m_ph = 4;
      default: m_ph = 0;
    endcase
    m_cnt = nc;
  endtask

  task automatic step(input bit rst, hreq, rreq, idl, iss, dn);
    @(negedge clk);
    mcu_rst_b = rst;
    halt_req  = hreq;
    run_req   = rreq;
    idle      = idl;
    issue     = iss;
    done      = dn;
    @(posedge clk);
    model_upd(rst, hreq, rreq, idl, iss, dn);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      checks++;
      if (dut_v() !== 6'b0) begin
        errors++;
        $display("FAIL reset cyc%0d got %b want 000000", i, dut_v());
      end
    end
  endtask

  task automatic test_halt_latency();
    logic [5:0] want [4];
    want[0] = 6'b100100;
    want[1] = 6'b000100;
    want[2] = 6'b010100;
    want[3] = 6'b010100;
    step(1, 1, 0, 1, 0, 0);
    checks++;
    if (dut_v() !== want[0]) begin
      errors++;
      $display("FAIL latency c1 got %b want %b", dut_v(), want[0]);
    end
    for (int c = 1; c < 4; c++) begin
      step(1, 0, 0, 1, 0, 0);
      checks++;
      if (dut_v() !== want[c] || dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL latency c%0d got %b want %b", c + 1, dut_v(), want[c]);
      end
    end
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (dut_v() !== 6'b0) begin
      errors++;
      $display("FAIL latency_back_to_run got %b want 000000", dut_v());
    end
  endtask

  task automatic test_drain_dones();
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0, 0);
    for (int c = 1; c <= 7; c++) begin
      step(1, 0, 0, 1, 0, (c == 5) || (c == 7));
      checks++;
      if (halt_status !== ((c == 7) ? 1'b1 : 1'b0) || dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL drain_dones c%0d got %b want %b", c + 1, dut_v(), exp_v());
      end
    end
    checks++;
    if (tmo !== 1'b0) begin
      errors++;
      $display("FAIL drain_dones_tmo got %b want 0", tmo);
    end
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    int n;
    step(0, 0, 0, 0, 0, 0);
    // drained exactly on the last allowed drain cycle: drain wins
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DLIM - 1; i++) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (halt_status !== 1'b0) begin
      errors++;
      $display("FAIL tie_early got %b want 0", halt_status);
    end
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (halt_status !== 1'b1 || tmo !== 1'b0 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL tie got %b want %b", dut_v(), exp_v());
    end
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // never idle: forced halt after the full drain window
    step(1, 1, 0, 0, 0, 0);
    n = 0;
    while (halt_status !== 1'b1 && n < 400) begin
      step(1, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != DLIM + 1 || tmo !== 1'b1 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL timeout steps %0d want %0d out %b want %b",
               n, DLIM + 1, dut_v(), exp_v());
    end
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    checks++;
    if (tmo !== 1'b1 || halt_status !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b want 1", tmo);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_v() !== 6'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 000000", dut_v());
    end
  endtask

  task automatic test_resume_priority();
    step(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 0, 0);
      checks++;
      if (run_ack !== 1'b0 || halt_status !== 1'b1) begin
        errors++;
        $display("FAIL prio_block got %b want %b", dut_v(), exp_v());
      end
    end
    step(1, 0, 1, 1, 0, 0);
    checks++;
    if (dut_v() !== 6'b001000) begin
      errors++;
      $display("FAIL resume_ack got %b want 001000", dut_v());
    end
    step(1, 0, 1, 1, 0, 0);
    checks++;
    if (dut_v() !== 6'b000000) begin
      errors++;
      $display("FAIL resume_run got %b want 000000", dut_v());
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 1, 1, 0);
      checks++;
      if (ovf !== ((i == 8) ? 1'b1 : 1'b0) || run_ack !== 1'b0) begin
        errors++;
        $display("FAIL ovf i%0d got %b want %b", i, dut_v(), exp_v());
      end
    end
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0, (i == 3));
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL ovf_drain i%0d got %b want %b", i, dut_v(), exp_v());
      end
    end
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (halt_status !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_floor got %b want %b", dut_v(), exp_v());
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    checks++;
    if (dut_v() !== 6'b0) begin
      errors++;
      $display("FAIL reset_drain got %b want 000000", dut_v());
    end
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (halt_status !== 1'b1 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL reset_cnt_clear got %b want %b", dut_v(), exp_v());
    end
  endtask

  task automatic test_random();
    bit r, h, q, i, s, d;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) != 0);
      h = ($urandom_range(0, 99) < 15);
      q = ($urandom_range(0, 99) < 40);
      i = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 99) < 35);
      d = ($urandom_range(0, 99) < 35);
      step(r, h, q, i, s, d);
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL random n%0d got %b want %b", n, dut_v(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt_latency();
    test_drain_dones();
    test_timeout();
    test_resume_priority();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
